// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type codes and IEC 60958 constants for the HDMI data-island scheduler.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_SPD          = 8'h83;
    localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

    localparam int IEC_FRAMES = 192;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Register-array sample-frame FIFO with a 4-deep parallel peek and 0..4 entry pop.
// Latency: a pushed entry is visible on peek the cycle after the push.
// Backpressure: ready is registered !full; the caller must not pop more than count.
module audio_sample_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_word,
    input  logic [2:0]                    pop_count,
    output logic [3:0][DATA_WIDTH-1:0]    peek_word,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_nxt;

    assign count_nxt = count + CW'(push) - CW'(pop_count);

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr + AW'(pop_count);
            count  <= count_nxt;
            ready  <= (count_nxt != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    for (genvar k = 0; k < 4; k++) begin : g_peek
        assign peek_word[k] = mem[rd_ptr + AW'(k)];
    end

endmodule

// File: rtl/packet_scheduler.sv
// Data-island packet selector: ACR, audio sample (layout 0/1), InfoFrames, null.
// Latency: packet_type/payload/present register on the edge that samples packet_enable.
// Backpressure: sample_ready is registered FIFO-not-full; no sample is ever dropped.
module packet_scheduler #(
    parameter int AUDIO_BIT_WIDTH  = 16,
    parameter int AUDIO_CHANNELS   = 2,
    parameter int FIFO_DEPTH       = 8,
    parameter int INFOFRAME_PERIOD = 1,
    parameter int FLUSH_TIMEOUT    = 256
) (
    input  logic                                       clk_pixel,
    input  logic                                       reset,
    input  logic                                       video_field_end,
    input  logic                                       packet_enable,
    input  logic [4:0]                                 packet_pixel_counter,
    input  logic                                       acr_request,
    input  logic                                       sample_valid,
    output logic                                       sample_ready,
    input  logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0]  sample_word,
    output logic [7:0]                                 packet_type,
    output logic [191:0]                               audio_sample_word_packet,
    output logic [3:0]                                 audio_sample_word_present_packet,
    output logic                                       sample_layout,
    output logic [7:0]                                 frame_counter
);

    import hdmi_packet_pkg::*;

    localparam int              W           = AUDIO_BIT_WIDTH;
    localparam int              SW          = AUDIO_CHANNELS * W;
    localparam int              PW          = 8 * W;
    localparam bit              LAYOUT      = (AUDIO_CHANNELS != 2);
    localparam int              CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int              AGW         = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [AGW-1:0]  AGE_MAX     = AGW'(FLUSH_TIMEOUT - 1);
    localparam int              FW          = $clog2(INFOFRAME_PERIOD + 1);
    localparam logic [FW-1:0]   FIELD_LAST  = FW'(INFOFRAME_PERIOD - 1);
    localparam logic [3:0]      L1_PRESENT  = 4'((1 << (AUDIO_CHANNELS / 2)) - 1);

    logic [3:0][SW-1:0] peek_word;
    logic [CW-1:0]      fifo_count;
    logic               fifo_push;
    logic [2:0]         pop_count;
    logic [2:0]         take_n;
    logic               audio_ready;
    logic               select_audio;
    logic [191:0]       nxt_payload;
    logic [3:0]         nxt_present;
    logic [PW-1:0]      frame0;

    logic [AGW-1:0]     age;
    logic [FW-1:0]      field_cnt;
    logic               acr_pending;
    logic               ai_due;
    logic               avi_due;
    logic               spd_due;
    logic [2:0]         fc_inc;
    logic [8:0]         fc_sum;

    assign sample_layout = LAYOUT;
    assign fifo_push     = sample_valid && sample_ready;

    audio_sample_fifo #(
        .DATA_WIDTH (SW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .push       (fifo_push),
        .push_word  (sample_word),
        .pop_count  (pop_count),
        .peek_word  (peek_word),
        .count      (fifo_count),
        .ready      (sample_ready)
    );

    assign take_n = LAYOUT ? 3'd1
                  : ((fifo_count >= CW'(4)) ? 3'd4 : 3'(fifo_count));

    // Layout 0 waits for a full packet unless the oldest sample has aged out.
    assign audio_ready = LAYOUT ? (fifo_count != '0)
                       : ((fifo_count >= CW'(4)) ||
                          ((fifo_count != '0) && (age == AGE_MAX)));

    assign select_audio = packet_enable && !video_field_end && !acr_pending && audio_ready;
    assign pop_count    = select_audio ? take_n : 3'd0;

    function automatic logic [23:0] left_justify(input logic [W-1:0] s);
        return 24'(s) << (24 - W);
    endfunction

    assign frame0 = PW'(peek_word[0]);

    always_comb begin
        nxt_payload = '0;
        nxt_present = '0;
        if (LAYOUT) begin
            for (int k = 0; k < 4; k++) begin
                if (k < AUDIO_CHANNELS / 2) begin
                    nxt_payload[k*48 +: 48] = {left_justify(frame0[(2*k+1)*W +: W]),
                                               left_justify(frame0[(2*k)*W +: W])};
                end
            end
            nxt_present = L1_PRESENT;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < take_n) begin
                    nxt_payload[k*48 +: 48] = {left_justify(peek_word[k][W +: W]),
                                               left_justify(peek_word[k][0 +: W])};
                    nxt_present[k]          = 1'b1;
                end
            end
        end
    end

    assign fc_inc = LAYOUT ? 3'd1 : popcount4(audio_sample_word_present_packet);
    assign fc_sum = {1'b0, frame_counter} + {6'b0, fc_inc};

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            packet_type                      <= PKT_NULL;
            audio_sample_word_packet         <= '0;
            audio_sample_word_present_packet <= '0;
            frame_counter                    <= '0;
            acr_pending                      <= 1'b0;
            ai_due                           <= 1'b1;
            avi_due                          <= 1'b1;
            spd_due                          <= 1'b1;
            field_cnt                        <= '0;
            age                              <= '0;
        end else begin
            if ((fifo_count == '0) || (pop_count != 3'd0)) begin
                age <= '0;
            end else if (age != AGE_MAX) begin
                age <= age + 1'b1;
            end

            if (packet_pixel_counter == 5'd31 && packet_type == PKT_AUDIO_SAMPLE) begin
                frame_counter <= (fc_sum >= 9'(IEC_FRAMES)) ? 8'(fc_sum - 9'(IEC_FRAMES))
                                                            : fc_sum[7:0];
            end

            if (acr_request) begin
                acr_pending <= 1'b1;
            end

            // Field end wins over a coincident enable: nothing is selected or popped.
            if (video_field_end) begin
                packet_type <= PKT_NULL;
                if (field_cnt == FIELD_LAST) begin
                    field_cnt <= '0;
                    ai_due    <= 1'b1;
                    avi_due   <= 1'b1;
                    spd_due   <= 1'b1;
                end else begin
                    field_cnt <= field_cnt + 1'b1;
                end
            end else if (packet_enable) begin
                if (acr_pending) begin
                    packet_type <= PKT_ACR;
                    acr_pending <= acr_request;
                end else if (audio_ready) begin
                    packet_type                      <= PKT_AUDIO_SAMPLE;
                    audio_sample_word_packet         <= nxt_payload;
                    audio_sample_word_present_packet <= nxt_present;
                end else if (ai_due) begin
                    packet_type <= PKT_AUDIO_INFO;
                    ai_due      <= 1'b0;
                end else if (avi_due) begin
                    packet_type <= PKT_AVI;
                    avi_due     <= 1'b0;
                end else if (spd_due) begin
                    packet_type <= PKT_SPD;
                    spd_due     <= 1'b0;
                end else begin
                    packet_type <= PKT_NULL;
                end
            end
        end
    end

endmodule

// File: doc/packet_scheduler.md
# packet_scheduler

Parametrised data-island packet scheduler for the HDMI transmitter, running entirely in the `clk_pixel` domain. It buffers multichannel audio sample frames in a FIFO and supports 2-channel (layout 0, up to 4 samples per packet) and 3–8-channel (layout 1, one sample per packet) audio. It flushes partial audio packets on timeout and re-sends InfoFrames every `INFOFRAME_PERIOD` fields. Its outputs select the packet generator (ACR, audio sample, AVI/SPD/audio InfoFrame, null) feeding the TMDS packet assembler.

## Interface
Parameters:
- `AUDIO_BIT_WIDTH`, 16: bits per channel sample; legal range 16..24.
- `AUDIO_CHANNELS`, 2: legal values 2, 4, 6, 8. The value 2 selects layout 0; any other value selects layout 1.
- `FIFO_DEPTH`, 8: sample-frame entries; power of two, ≥4.
- `INFOFRAME_PERIOD`, 1: fields between InfoFrame resends; ≥1.
- `FLUSH_TIMEOUT`, 256: clk_pixel cycles before a partial layout-0 packet is allowed.

Ports:
- `clk_pixel`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `video_field_end`, in, 1: single-cycle pulse at the end of each field.
- `packet_enable`, in, 1: pulse one cycle before a data-island packet slot.
- `packet_pixel_counter`, in, 5: pixel position within the current packet (0..31).
- `acr_request`, in, 1: single-cycle pulse requesting an ACR packet.
- `sample_valid`, in, 1: sample frame offered.
- `sample_ready`, out, 1: FIFO not full.
- `sample_word`, in, `AUDIO_CHANNELS*AUDIO_BIT_WIDTH`: channel c occupies `[c*W +: W]`.
- `packet_type`, out, 8: selected packet type.
- `audio_sample_word_packet`, out, 192: four 48-bit subpackets.
- `audio_sample_word_present_packet`, out, 4: subpacket present bits.
- `sample_layout`, out, 1: 0 = layout 0, 1 = layout 1; constant.
- `frame_counter`, out, 8: IEC 60958 frame index of the first sample in the current packet, 0..191.

## Operation
- **FIFO handshake:** a push occurs when `sample_valid && sample_ready`. `sample_ready` = !full, registered. No sample is ever dropped.
- **Sample packing:** each sample is left-justified into a 24-bit slot, with unused LSBs zero.
- **Subpacket format:** a 48-bit subpacket holds the even channel in `[23:0]` and the odd channel in `[47:24]`.
- **Layout 0 readiness:** a packet is ready when count ≥4, or when 1 ≤ count ≤3 and the age counter has reached `FLUSH_TIMEOUT-1`.
  - The packet takes n = min(count, 4) entries. The oldest entry goes in subpacket 0.
  - Present bits = `(1<<n)-1`. Absent subpackets are zero.
- **Layout 1 readiness:** a packet is ready when count ≥1. It takes 1 entry, with subpacket k = channels 2k and 2k+1.
  - Present bits = `(1<<(AUDIO_CHANNELS/2))-1`; for example, 6 channels gives `4'b0111`.
- **Age counter:** clears whenever count = 0 or a pop occurs. Otherwise it increments, saturating at `FLUSH_TIMEOUT-1`.
- **ACR pending latch:** `acr_request` sets `acr_pending`. If the request coincides with an ACR selection, `acr_pending` stays set.
- **Selection:** on `packet_enable`, choose the highest-priority packet from this list:
  - ACR pending → 0x01.
  - Audio ready → 0x02; pop the entries and latch the payload and present bits.
  - Audio InfoFrame due → 0x84.
  - AVI due → 0x82.
  - SPD due → 0x83.
  - Otherwise null → 0x00.
  - Each InfoFrame's "due" flag clears when it is selected.
- **Field counter:** counts `video_field_end` pulses modulo `INFOFRAME_PERIOD`. On wrap to 0, all three due flags set.
- **Field end:** `video_field_end` forces `packet_type` to 0x00, and overrides a coincident `packet_enable`.
- **Frame counter:** at `packet_pixel_counter == 31` with `packet_type == 0x02`, `frame_counter` advances by the number of samples in that packet, modulo 192. The sample count is the popcount of the present bits in layout 0, and 1 in layout 1.
  - Example: 190 + 4 → 2.
- **Simultaneous push and pop:** count updates by +1 − n in the same cycle.

## Timing
- **Reset values:**
  - `packet_type` = 0x00; payload = 0; present bits = 0; `frame_counter` = 0.
  - `sample_ready` = 1; FIFO empty.
  - `acr_pending` = 0; all due flags = 1; field counter = 0; age counter = 0.
- **Selection latency:** `packet_type`, payload and present bits are registered. They update on the clock edge that samples `packet_enable` and hold until the next selection or field end.
- **`sample_ready` latency:** reflects the count one cycle after each push or pop.
- **Mid-operation reset:** reset asserted mid-packet returns all state to reset values immediately (asynchronous). Behaviour resumes on the first edge after deassertion.

## Structure
- Package `hdmi_packet_pkg` holds:
  - Packet type constants: `PKT_NULL`, `PKT_ACR`, `PKT_AUDIO_SAMPLE`, `PKT_AVI`, `PKT_SPD`, `PKT_AUDIO_INFO`.
  - The constant `IEC_FRAMES = 192`.
- Sub-module `audio_sample_fifo`: a register-array FIFO with a 4-entry parallel read port, variable pop count 0..4, and count output.

## Test plan
- **Layout 0 full packets:** `AUDIO_CHANNELS=2`, push 8 frames, two `packet_enable` pulses.
  - Expect `packet_type` 0x02 twice with present `4'b1111`.
  - Expect `frame_counter` 0 → 4 → 8 after each pixel 31.
- **Partial flush:** push 3 frames, idle `FLUSH_TIMEOUT` cycles, then `packet_enable` → 0x02 with present `4'b0111` and subpacket 3 = 0.
- **Layout 1, 6 channels, 16-bit:** push channel c = 0x1000+c → present `4'b0111`. Subpacket 1 must be `{24'h100300, 24'h100200}`.
- **Priority:** `acr_request` together with a ready audio packet → 0x01, then 0x02 on the next enable. After reset, idle enables give 0x84, 0x82, 0x83, then 0x00.
- **Backpressure and wrap:**
  - Fill the FIFO to `FIFO_DEPTH` → `sample_ready` = 0.
  - Push and pop in the same cycle → count is consistent and no loss.
  - `frame_counter` wraps from 188 to 0.
- **Field, period and reset:**
  - With `INFOFRAME_PERIOD=2`, InfoFrames are re-sent only after every second `video_field_end`.
  - Asserting reset during packet pixel 15 makes all outputs reset values immediately.
